// File: rtl/spi_regbank_pkg.sv
// Shared address-map helpers and register-kind enum for the SPI register bank.
package spi_regbank_pkg;

  typedef enum logic [2:0] {RK_CFG, RK_STATUS, RK_FLAGS, RK_MASK, RK_NONE} reg_kind_e;

  function automatic int cfg_base(input int num_cfg, input int num_status);
    return 0;
  endfunction

  function automatic int status_base(input int num_cfg, input int num_status);
    return cfg_base(num_cfg, num_status) + num_cfg;
  endfunction

  function automatic int irq_flags_addr(input int num_cfg, input int num_status);
    return status_base(num_cfg, num_status) + num_status;
  endfunction

  function automatic int irq_mask_addr(input int num_cfg, input int num_status);
    return irq_flags_addr(num_cfg, num_status) + 1;
  endfunction

endpackage

// File: rtl/spi_irq_ctrl.sv
// Edge-triggered sticky interrupt flags (W1C, set wins) with mask and registered irq output.
module spi_irq_ctrl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               ena_i,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic               flags_we_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] wdata_i,
  output logic [NUM_IRQ-1:0] flags_o,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic               irq_o
);

  logic [NUM_IRQ-1:0] src_q, flags_q, flags_d, mask_q, mask_d, rise, clr;
  logic               irq_q, irq_d;

  // History tracks even with ena low, so re-enabling never fakes an edge.
  always_comb begin
    rise    = irq_src_i & ~src_q;
    clr     = flags_we_i ? wdata_i : '0;
    flags_d = ena_i ? ((flags_q & ~clr) | rise) : flags_q;
    mask_d  = mask_we_i ? wdata_i : mask_q;
    irq_d   = |(flags_q & mask_q);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      src_q   <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      src_q   <= irq_src_i;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  assign flags_o = flags_q;
  assign mask_o  = mask_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI target front end: frame = {rw, addr, data}, MSB first; emits a 1-clk write strobe in the clk domain.
module spi_peripheral #(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [1:0]        mode_i,
  input  logic              cs_n_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [REG_W-1:0]  status_i,
  input  logic [REG_W-1:0]  rdata_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [REG_W-1:0]  wdata_o,
  output logic              we_o,
  output logic              wr_rdn_o
);

  localparam int FRAME = 1 + ADDR_W + REG_W;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam int RX_W  = (REG_W > ADDR_W) ? REG_W : ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME);

  logic [2:0]        sclk_s_q, cs_s_q;
  logic [1:0]        mosi_s_q;
  logic [RX_W-2:0]   rx_q;
  logic [RX_W-1:0]   rx_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [REG_W-1:0]  tx_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q, we_q;
  logic              edge_now, edge_prev, active, start, sample, shift;

  // Normalising by CPOL^CPHA makes the sampling edge always a rising edge.
  assign edge_now  = sclk_s_q[1] ^ mode_i[1] ^ mode_i[0];
  assign edge_prev = sclk_s_q[2] ^ mode_i[1] ^ mode_i[0];
  assign active    = ~cs_s_q[1];
  assign start     = cs_s_q[2] & ~cs_s_q[1];
  assign sample    = active & edge_now & ~edge_prev;
  assign shift     = active & ~edge_now & edge_prev;
  assign rx_d      = {rx_q, mosi_s_q[1]};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sclk_s_q <= '0;
      cs_s_q   <= '1;
      mosi_s_q <= '0;
      rx_q     <= '0;
      cnt_q    <= '0;
      tx_q     <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      sclk_s_q <= {sclk_s_q[1:0], sclk_i};
      cs_s_q   <= {cs_s_q[1:0], cs_n_i};
      mosi_s_q <= {mosi_s_q[0], mosi_i};
      we_q     <= 1'b0;
      if (!active) begin
        cnt_q <= '0;
      end else if (sample && cnt_q != CNT_FULL) begin
        rx_q  <= rx_d[RX_W-2:0];
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_ADDR) begin
          addr_q <= rx_d[ADDR_W-1:0];
          rw_q   <= rx_d[ADDR_W];
        end
        if (cnt_q == CNT_LAST) begin
          wdata_q <= rx_d[REG_W-1:0];
          we_q    <= rw_q;
        end
      end
      // Read data is loaded on the first shift edge after the address is complete.
      if (start)                         tx_q <= status_i;
      else if (shift && cnt_q == CNT_DATA) tx_q <= rdata_i;
      else if (shift && cnt_q != '0)     tx_q <= {tx_q[REG_W-2:0], 1'b0};
    end
  end

  assign miso_o   = tx_q[REG_W-1];
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign we_o     = we_q;
  assign wr_rdn_o = rw_q;

endmodule

// File: rtl/spi_regbank.sv
// SPI-accessed register bank: RW config, shadowed RO status, W1C irq flags and irq mask.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int NUM_CFG    = 6,
  parameter int NUM_STATUS = 3,
  parameter int REG_WIDTH  = 8,
  parameter int NUM_IRQ    = 4,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RESET = '0
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             ena,
  input  logic [1:0]                       mode,
  input  logic                             spi_cs_n,
  input  logic                             spi_clk,
  input  logic                             spi_mosi,
  output logic                             spi_miso,
  output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
  output logic [NUM_CFG-1:0]               cfg_wr_pulse,
  input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
  input  logic [NUM_IRQ-1:0]               irq_src,
  output logic                             irq
);

  localparam int ADDR_WIDTH = $clog2(NUM_CFG + NUM_STATUS + 2);
  localparam int W = REG_WIDTH;

  logic [ADDR_WIDTH-1:0]        spi_addr;
  logic [W-1:0]                 spi_wdata, rdata;
  logic                         spi_we, wr_en, unused_wr_rdn;
  int                           addr_int;
  reg_kind_e                    kind;
  logic [NUM_CFG*W-1:0]         cfg_q, cfg_d;
  logic [NUM_CFG-1:0]           pulse_q, pulse_d;
  logic [NUM_STATUS*W-1:0]      shadow_q;
  logic [NUM_IRQ-1:0]           flags, mask;

  spi_peripheral #(.ADDR_W(ADDR_WIDTH), .REG_W(W)) u_spi (
    .clk      (clk),
    .rstb     (rstb),
    .mode_i   (mode),
    .cs_n_i   (spi_cs_n),
    .sclk_i   (spi_clk),
    .mosi_i   (spi_mosi),
    .miso_o   (spi_miso),
    .status_i ('0),
    .rdata_i  (rdata),
    .addr_o   (spi_addr),
    .wdata_o  (spi_wdata),
    .we_o     (spi_we),
    .wr_rdn_o (unused_wr_rdn)
  );

  assign addr_int = int'(spi_addr);
  assign wr_en    = spi_we & ena;

  always_comb begin
    kind = RK_NONE;
    if (addr_int >= cfg_base(NUM_CFG, NUM_STATUS) && addr_int < status_base(NUM_CFG, NUM_STATUS))
      kind = RK_CFG;
    else if (addr_int >= status_base(NUM_CFG, NUM_STATUS) && addr_int < irq_flags_addr(NUM_CFG, NUM_STATUS))
      kind = RK_STATUS;
    else if (addr_int == irq_flags_addr(NUM_CFG, NUM_STATUS))
      kind = RK_FLAGS;
    else if (addr_int == irq_mask_addr(NUM_CFG, NUM_STATUS))
      kind = RK_MASK;
  end

  always_comb begin
    pulse_d = '0;
    cfg_d   = cfg_q;
    for (int k = 0; k < NUM_CFG; k++) begin
      pulse_d[k] = wr_en && (kind == RK_CFG) && (addr_int == cfg_base(NUM_CFG, NUM_STATUS) + k);
      if (pulse_d[k]) cfg_d[k*W +: W] = spi_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cfg_q    <= CFG_RESET;
      pulse_q  <= '0;
      shadow_q <= '0;
    end else begin
      cfg_q   <= cfg_d;
      pulse_q <= pulse_d;
      if (ena) shadow_q <= status_regs;
    end
  end

  // Unmapped addresses and flag/mask bits above NUM_IRQ read as zero.
  always_comb begin
    rdata = '0;
    case (kind)
      RK_CFG:
        for (int k = 0; k < NUM_CFG; k++)
          if (addr_int == cfg_base(NUM_CFG, NUM_STATUS) + k) rdata = cfg_q[k*W +: W];
      RK_STATUS:
        for (int k = 0; k < NUM_STATUS; k++)
          if (addr_int == status_base(NUM_CFG, NUM_STATUS) + k) rdata = shadow_q[k*W +: W];
      RK_FLAGS: rdata = W'(flags);
      RK_MASK:  rdata = W'(mask);
      default:  rdata = '0;
    endcase
  end

  spi_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk        (clk),
    .rstb       (rstb),
    .ena_i      (ena),
    .irq_src_i  (irq_src),
    .flags_we_i (wr_en && (kind == RK_FLAGS)),
    .mask_we_i  (wr_en && (kind == RK_MASK)),
    .wdata_i    (spi_wdata[NUM_IRQ-1:0]),
    .flags_o    (flags),
    .mask_o     (mask),
    .irq_o      (irq)
  );

  assign config_regs  = cfg_q;
  assign cfg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank: SPI mode-0 frames {rw, addr[3:0], data[7:0]}, table vectors plus irq/reset sequences.
module tb_spi_regbank;

  localparam logic [47:0] C0 = 48'h0605_0403_0201;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rstb, ena, spi_cs_n, spi_clk, spi_mosi, spi_miso, irq;
  logic [1:0]  mode;
  logic [47:0] config_regs;
  logic [5:0]  cfg_wr_pulse;
  logic [23:0] status_regs;
  logic [3:0]  irq_src;

  int n_cmp = 0;
  int n_fail = 0;
  int pulse_cycles = 0;
  logic [5:0] last_pulse = '0;

  typedef struct {
    logic       en;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic [5:0] exp_pulse;
    logic [47:0] exp_cfg;
  } vec_t;
  vec_t vecs[$];

  spi_regbank #(
    .NUM_CFG(6), .NUM_STATUS(3), .REG_WIDTH(8), .NUM_IRQ(4), .CFG_RESET(C0)
  ) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .config_regs(config_regs), .cfg_wr_pulse(cfg_wr_pulse), .status_regs(status_regs),
    .irq_src(irq_src), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstb && cfg_wr_pulse != '0) begin
      pulse_cycles <= pulse_cycles + 1;
      last_pulse   <= cfg_wr_pulse;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic so);
    spi_mosi = b;
    clks(HALF);
    so = spi_miso;
    spi_clk = 1'b1;
    clks(HALF);
    spi_clk = 1'b0;
  endtask

  task automatic spi_xfer(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd);
    logic [12:0] fr;
    logic so;
    fr = {wr, addr, wd};
    rd = '0;
    spi_cs_n = 1'b0;
    clks(HALF);
    for (int i = 12; i >= 0; i--) begin
      spi_bit(fr[i], so);
      if (i < 8) rd[i] = so;
    end
    clks(HALF);
    spi_cs_n = 1'b1;
    clks(2 * HALF);
  endtask

  task automatic add(input logic en, input logic wr, input logic [3:0] a, input logic [7:0] wd,
                     input logic [7:0] exp_rd, input logic [5:0] p, input logic [47:0] c);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = a; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_pulse = p; v.exp_cfg = c;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] rd;
    int p0;
    bit seen;

    add(1, 0, 4'd10, 8'h00, 8'h00, 6'h00, C0);
    add(1, 0, 4'd9,  8'h00, 8'h00, 6'h00, C0);
    add(1, 1, 4'd3,  8'hA5, 8'h00, 6'b001000, 48'h0605_A503_0201);
    add(1, 0, 4'd3,  8'h00, 8'hA5, 6'h00, 48'h0605_A503_0201);
    add(1, 0, 4'd6,  8'h00, 8'h11, 6'h00, 48'h0605_A503_0201);
    add(1, 0, 4'd7,  8'h00, 8'h22, 6'h00, 48'h0605_A503_0201);
    add(1, 0, 4'd8,  8'h00, 8'h33, 6'h00, 48'h0605_A503_0201);
    add(1, 1, 4'd7,  8'hFF, 8'h00, 6'h00, 48'h0605_A503_0201);
    add(1, 0, 4'd7,  8'h00, 8'h22, 6'h00, 48'h0605_A503_0201);
    add(1, 1, 4'd13, 8'h5A, 8'h00, 6'h00, 48'h0605_A503_0201);
    add(1, 0, 4'd13, 8'h00, 8'h00, 6'h00, 48'h0605_A503_0201);
    add(1, 1, 4'd0,  8'h3C, 8'h00, 6'b000001, 48'h0605_A503_023C);
    add(1, 1, 4'd5,  8'hC3, 8'h00, 6'b100000, 48'hC305_A503_023C);
    add(1, 0, 4'd5,  8'h00, 8'hC3, 6'h00, 48'hC305_A503_023C);
    add(1, 0, 4'd0,  8'h00, 8'h3C, 6'h00, 48'hC305_A503_023C);
    add(0, 1, 4'd1,  8'h77, 8'h00, 6'h00, 48'hC305_A503_023C);
    add(1, 0, 4'd1,  8'h00, 8'h02, 6'h00, 48'hC305_A503_023C);
    add(1, 1, 4'd10, 8'hFF, 8'h00, 6'h00, 48'hC305_A503_023C);
    add(1, 0, 4'd10, 8'h00, 8'h0F, 6'h00, 48'hC305_A503_023C);
    add(1, 1, 4'd10, 8'h05, 8'h00, 6'h00, 48'hC305_A503_023C);
    add(1, 0, 4'd10, 8'h00, 8'h05, 6'h00, 48'hC305_A503_023C);
    add(1, 0, 4'd15, 8'h00, 8'h00, 6'h00, 48'hC305_A503_023C);
    add(1, 0, 4'd11, 8'h00, 8'h00, 6'h00, 48'hC305_A503_023C);

    rstb = 1'b0; ena = 1'b1; mode = 2'b00;
    spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    status_regs = {8'h33, 8'h22, 8'h11};
    irq_src = 4'b0000;
    clks(3);
    check("reset config", config_regs, C0);
    check("reset irq", irq, 0);
    check("reset pulse", cfg_wr_pulse, 0);
    check("reset miso", spi_miso, 0);
    rstb = 1'b1;
    clks(3);

    foreach (vecs[i]) begin
      ena = vecs[i].en;
      p0 = pulse_cycles;
      spi_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, rd);
      ena = 1'b1;
      if (!vecs[i].wr)
        check($sformatf("vec%0d read a%0d", i, vecs[i].addr), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d pulse cycles", i), pulse_cycles - p0, (vecs[i].exp_pulse != 0) ? 1 : 0);
      if (vecs[i].exp_pulse != 0)
        check($sformatf("vec%0d pulse value", i), last_pulse, vecs[i].exp_pulse);
      check($sformatf("vec%0d config", i), config_regs, vecs[i].exp_cfg);
    end

    // mask = 0x05: irq_src[2] rise sets flag, irq follows one clk later
    irq_src = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    check("irq before lag", irq, 0);
    @(negedge clk);
    check("irq after flag", irq, 1);
    clks(1);
    spi_xfer(0, 4'd9, 8'h00, rd);
    check("flags after src2", rd, 8'h04);
    irq_src = 4'b0110;
    clks(3);
    check("irq masked src1", irq, 1);
    spi_xfer(0, 4'd9, 8'h00, rd);
    check("flags after src1", rd, 8'h06);
    spi_xfer(1, 4'd9, 8'h04, rd);
    clks(2);
    check("irq after w1c", irq, 0);
    spi_xfer(0, 4'd9, 8'h00, rd);
    check("flags after w1c", rd, 8'h02);

    // W1C of bit 0 in the same cycle as its rising source: set wins
    seen = 0;
    fork
      spi_xfer(1, 4'd9, 8'h01, rd);
      begin
        for (int t = 0; t < 600 && !seen; t++) begin
          if (dut.spi_we) begin
            irq_src = 4'b0111;
            seen = 1;
          end else begin
            clks(1);
          end
        end
      end
    join
    check("w1c strobe seen", seen, 1);
    spi_xfer(0, 4'd9, 8'h00, rd);
    check("flags set wins", rd, 8'h03);
    check("irq set wins", irq, 1);

    // Reset in the middle of a write frame
    spi_cs_n = 1'b0;
    clks(HALF);
    begin
      logic [12:0] fr;
      logic so;
      fr = {1'b1, 4'd1, 8'h99};
      for (int i = 12; i >= 7; i--) spi_bit(fr[i], so);
    end
    rstb = 1'b0;
    irq_src = 4'b0000;
    clks(2);
    check("midreset config", config_regs, C0);
    check("midreset pulse", cfg_wr_pulse, 0);
    check("midreset irq", irq, 0);
    check("midreset miso", spi_miso, 0);
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    clks(4);
    rstb = 1'b1;
    clks(4);
    check("post reset config", config_regs, C0);
    p0 = pulse_cycles;
    spi_xfer(1, 4'd1, 8'h99, rd);
    check("post reset pulse cycles", pulse_cycles - p0, 1);
    check("post reset pulse value", last_pulse, 6'b000010);
    check("post reset config write", config_regs, 48'h0605_0403_9901);
    spi_xfer(0, 4'd1, 8'h00, rd);
    check("post reset readback", rd, 8'h99);
    spi_xfer(0, 4'd9, 8'h00, rd);
    check("post reset flags", rd, 8'h00);
    spi_xfer(0, 4'd10, 8'h00, rd);
    check("post reset mask", rd, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
